// File: rtl/lcd_led_pwm_if.sv
// Avalon-MM slave bus bundle for the LCD LED/backlight PWM controller.
// The master drives address/strobes/data; the slave returns a combinational readdata.
interface lcd_led_pwm_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/lcd_led_pwm.sv
// LED/backlight output controller: static levels with atomic set/clear, plus per-channel
// PWM dimming driven by a shared prescaler, double-buffered duties and a wrap interrupt.
module lcd_led_pwm #(
    parameter int          WIDTH          = 8,
    parameter int          PWM_BITS       = 8,
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    lcd_led_pwm_if.slave     bus,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    localparam int DW = PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    pwmen_q;
    logic [15:0]         prescale_q;
    logic [4:0]          duty_sel_q;
    logic [15:0]         pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                wrap_flag_q, wrap_flag_d;
    logic                irq_en_q, irq_en_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [DW-1:0]       staging_q [WIDTH];
    logic [DW-1:0]       shadow_q  [WIDTH];
    logic [31:0]         rdata;

    logic we, tick, wrap;
    logic [WIDTH-1:0] wd_w;

    assign we   = bus.chipselect & ~bus.write_n;
    assign wd_w = bus.writedata[WIDTH-1:0];
    assign tick = (pre_cnt_q == prescale_q);
    assign wrap = tick & (&pwm_cnt_q);

    always_comb begin
        data_d = data_q;
        if (we) begin
            case (bus.address)
                3'd0:    data_d = wd_w;
                3'd1:    data_d = data_q | wd_w;
                3'd2:    data_d = data_q & ~wd_w;
                default: data_d = data_q;
            endcase
        end
    end

    // A PRESCALE write restarts the prescaler but a coincident tick still advances pwm_cnt.
    assign pre_cnt_d   = ((we && bus.address == 3'd4) || tick) ? 16'd0 : pre_cnt_q + 16'd1;
    assign pwm_cnt_d   = tick ? pwm_cnt_q + PWM_ONE : pwm_cnt_q;
    assign wrap_flag_d = wrap | (wrap_flag_q & ~(we && bus.address == 3'd7 && bus.writedata[0]));
    assign irq_en_d    = (we && bus.address == 3'd7) ? bus.writedata[1] : irq_en_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        assign out_d[gi] = pwmen_q[gi]
                         ? (data_q[gi] & ({1'b0, pwm_cnt_q} < shadow_q[gi]))
                         : data_q[gi];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            pwmen_q     <= '0;
            prescale_q  <= PRESCALE_RESET;
            duty_sel_q  <= '0;
            pre_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            wrap_flag_q <= 1'b0;
            irq_en_q    <= 1'b0;
            out_q       <= '0;
        end else begin
            data_q      <= data_d;
            pre_cnt_q   <= pre_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            wrap_flag_q <= wrap_flag_d;
            irq_en_q    <= irq_en_d;
            out_q       <= out_d;
            if (we && bus.address == 3'd3) pwmen_q    <= wd_w;
            if (we && bus.address == 3'd4) prescale_q <= bus.writedata[15:0];
            if (we && bus.address == 3'd5) duty_sel_q <= bus.writedata[4:0];
        end
    end

    // Shadow copies the pre-edge staging value, so a DUTY write on a wrap edge waits a period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                staging_q[i] <= '0;
                shadow_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (we && bus.address == 3'd6 && duty_sel_q == 5'(i))
                    staging_q[i] <= bus.writedata[DW-1:0];
                if (wrap)
                    shadow_q[i] <= staging_q[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            3'd0: rdata[WIDTH-1:0] = data_q;
            3'd3: rdata[WIDTH-1:0] = pwmen_q;
            3'd4: rdata[15:0]      = prescale_q;
            3'd5: rdata[4:0]       = duty_sel_q;
            3'd6: begin
                for (int i = 0; i < WIDTH; i++)
                    if (duty_sel_q == 5'(i)) rdata[DW-1:0] = staging_q[i];
            end
            3'd7: rdata[1:0] = {irq_en_q, wrap_flag_q};
            default: rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign out_port     = out_q;
    assign irq          = wrap_flag_q & irq_en_q;
endmodule

// File: tb/tb_lcd_led_pwm.sv
// Directed bench for lcd_led_pwm (WIDTH=8, PWM_BITS=4, PRESCALE_RESET=3): register map,
// PWM waveform, duty boundaries, interrupt set/clear races and asynchronous reset.
module tb_lcd_led_pwm;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;
    logic       irq;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    lcd_led_pwm_if bus ();

    lcd_led_pwm #(.WIDTH(8), .PWM_BITS(4), .PRESCALE_RESET(16'd3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a; #1;
        check(tag, bus.readdata, exp);
    endtask

    // Returns just after the wrap edge that set wrap_flag (flag cleared beforehand by caller).
    task automatic wait_flag(input string tag);
        int n = 0;
        bus.address = 3'd7; #1;
        while (bus.readdata[0] !== 1'b1 && n < 200) begin
            step(); n++;
        end
        check(tag, 32'(bus.readdata[0]), 32'd1);
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            step();
            if (out_port[0] === 1'b1) h++;
        end
    endtask

    initial begin
        int h, n, c0;
        bus.address = 3'd0; bus.writedata = 32'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        repeat (3) @(posedge clk);
        #1; reset_n = 1'b1;

        check("rst_out", 32'(out_port), 32'h00);
        check("rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 8; a++)
            rd_check($sformatf("rst_rd%0d", a), 3'(a), (a == 4) ? 32'd3 : 32'd0);
        step();

        wr(3'd0, 32'hA5);
        rd_check("data_a5", 3'd0, 32'hA5);
        check("out_lat", 32'(out_port), 32'h00);
        step(); check("out_a5", 32'(out_port), 32'hA5);
        wr(3'd1, 32'h0A);
        rd_check("data_af", 3'd0, 32'hAF);
        rd_check("outset_rd", 3'd1, 32'd0);
        step(); check("out_af", 32'(out_port), 32'hAF);
        wr(3'd2, 32'h81);
        rd_check("data_2e", 3'd0, 32'h2E);
        rd_check("outclr_rd", 3'd2, 32'd0);
        step(); check("out_2e", 32'(out_port), 32'h2E);

        wr(3'd4, 32'd1); wr(3'd0, 32'd1); wr(3'd3, 32'd1); wr(3'd5, 32'd0); wr(3'd6, 32'd4);
        rd_check("prescale_rd", 3'd4, 32'd1);
        rd_check("duty_rd4", 3'd6, 32'd4);
        wr(3'd7, 32'd1);
        wait_flag("wrap_d4");
        for (int k = 1; k <= 64; k++) begin
            step();
            check($sformatf("pwm4_k%0d", k), 32'(out_port[0]), (((k - 1) % 32) < 8) ? 32'd1 : 32'd0);
        end
        check("pwm4_hi_bits", 32'(out_port[7:1]), 32'd0);

        wr(3'd6, 32'd0); wr(3'd7, 32'd1); wait_flag("wrap_d0");
        count_high(32, h); check("duty0_highs", 32'(h), 32'd0);
        wr(3'd6, 32'd16); wr(3'd7, 32'd1); wait_flag("wrap_d16");
        count_high(32, h); check("duty16_highs", 32'(h), 32'd32);

        wr(3'd5, 32'd9); wr(3'd6, 32'd7);
        rd_check("dsel9_duty_rd", 3'd6, 32'd0);
        rd_check("dsel9_rd", 3'd5, 32'd9);
        wr(3'd7, 32'd1); wait_flag("wrap_dsel9");
        count_high(32, h); check("dsel9_highs", 32'(h), 32'd32);
        check("dsel9_hi_bits", 32'(out_port[7:1]), 32'd0);
        wr(3'd5, 32'd0);
        rd_check("duty_rd16", 3'd6, 32'd16);

        wr(3'd7, 32'd1); wait_flag("wrap_irq");
        wr(3'd7, 32'd1); wr(3'd7, 32'd2);
        check("irq_before", 32'(irq), 32'd0);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin step(); n++; end
        check("irq_rise_cycles", 32'(n), 32'd30);
        repeat (31) step();
        wr(3'd7, 32'd3);
        check("irq_setwins", 32'(irq), 32'd1);
        rd_check("status_setwins", 3'd7, 32'd3);
        wr(3'd7, 32'd3);
        check("irq_cleared", 32'(irq), 32'd0);
        rd_check("status_cleared", 3'd7, 32'd2);

        repeat (30) step();
        wr(3'd6, 32'd4);
        rd_check("duty_rd_race", 3'd6, 32'd4);
        count_high(32, h); check("race_old_duty", 32'(h), 32'd32);
        count_high(32, h); check("race_new_duty", 32'(h), 32'd8);

        repeat (2) step();
        check("pre_rst_out0", 32'(out_port[0]), 32'd1);
        check("pre_rst_irq", 32'(irq), 32'd1);
        #2; reset_n = 1'b0; #1;
        check("async_rst_out", 32'(out_port), 32'h00);
        check("async_rst_irq", 32'(irq), 32'd0);
        @(posedge clk); #3;
        reset_n = 1'b1; c0 = cyc;
        for (int a = 0; a < 8; a++)
            rd_check($sformatf("rel_rd%0d", a), 3'(a), (a == 4) ? 32'd3 : 32'd0);
        bus.address = 3'd7; #1;
        while (bus.readdata[0] !== 1'b1 && (cyc - c0) < 200) step();
        check("restart_wrap_cycles", 32'(cyc - c0), 32'd64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
